rx_lvds_deframer: RTL and testbench



---
 rtl/rx_lvds_pkg.sv | 31 +++
 rtl/rx_lvds_deframer_if.sv | 27 ++
 rtl/lvds_dibit_deser.sv | 44 ++++
 rtl/rx_lvds_deframer.sv | 178 +++++++++++++++++
 tb/tb_rx_lvds_deframer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_lvds_pkg.sv
// rx_lvds_pkg
// Shared definitions for the LVDS receive deframer:
//   - rx_state_e        : framing FSM states (HUNT, LEN, PAYLOAD, CHECK)
//   - STAT_*            : bit positions of the sticky flags in the status byte
//   - DEFAULT_SYNC_WORD : default frame sync byte
//   - DEFAULT_MAX_LEN   : default largest accepted payload length
//   - len_ok()          : length field acceptance test
package rx_lvds_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } rx_state_e;

  // Status byte layout: {frame_cnt[3:0], overflow, len_err, chk_err, frame_ok}
  localparam logic [1:0] STAT_FRAME_OK = 2'd0;
  localparam logic [1:0] STAT_CHK_ERR  = 2'd1;
  localparam logic [1:0] STAT_LEN_ERR  = 2'd2;
  localparam logic [1:0] STAT_OVERFLOW = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;
  localparam logic [7:0] DEFAULT_MAX_LEN   = 8'd64;

  // A length byte is usable when it is non-zero and no larger than max_len.
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/rx_lvds_deframer_if.sv
// rx_lvds_deframer_if
// Write-side bus between the deframer and the rx packet fifo / length register.
//   pkt_wr_en/pkt_data  : payload byte write into the rx packet fifo
//   len_wr_en/len_data  : frame length write into the packet-length register
//   frame_done          : one-cycle pulse at the end of every accepted frame
//   fifo_full           : fifo back-pressure, driven by the fifo side
// Modports: master = deframer, slave = fifo / length register side.
interface rx_lvds_deframer_if;

  logic       pkt_wr_en;
  logic [7:0] pkt_data;
  logic       len_wr_en;
  logic [7:0] len_data;
  logic       frame_done;
  logic       fifo_full;

  modport master (
    output pkt_wr_en, pkt_data, len_wr_en, len_data, frame_done,
    input  fifo_full
  );

  modport slave (
    input  pkt_wr_en, pkt_data, len_wr_en, len_data, frame_done,
    output fifo_full
  );

endinterface

// File: rtl/lvds_dibit_deser.sv
// lvds_dibit_deser
// Dibit-to-byte deserialiser for the LVDS receive path.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   dibit_i         : one dibit per clock, bit[1] earliest, bytes MSB first
//   align_clr_i     : holds the dibit counter at 0 (framer is hunting for sync)
//   sr_d_o          : shift register contents including this cycle's dibit
//   byte_valid_o    : this cycle's dibit is the 4th of a byte; sr_d_o is the byte
module lvds_dibit_deser (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] dibit_i,
  input  logic       align_clr_i,
  output logic [7:0] sr_d_o,
  output logic       byte_valid_o
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [1:0] cnt_q;

  // The framer looks at the shifted value in the same cycle so that sync
  // detection and byte capture are not delayed by an extra register.
  assign sr_d         = {sr_q[5:0], dibit_i};
  assign sr_d_o       = sr_d;
  assign byte_valid_o = (cnt_q == 2'd3);

  // Counter stays at 0 while hunting, so the first byte after sync completes
  // on the 4th dibit following the sync's last dibit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= 8'h00;
      cnt_q <= 2'd0;
    end else begin
      sr_q <= sr_d;
      if (align_clr_i) begin
        cnt_q <= 2'd0;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/rx_lvds_deframer.sv
// rx_lvds_deframer
// Receives a dibit stream, hunts for SYNC_WORD at any dibit alignment, then
// parses length, payload and (optionally) an 8-bit mod-256 checksum.
// Payload bytes go to the rx packet fifo; the length is written at the end of
// every accepted frame. A status register reports sticky error/ok flags and a
// 4-bit accepted-frame counter.
// Parameters: SYNC_WORD (frame sync byte), MAX_LEN (largest payload length).
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   from_lvds                  : incoming dibit
//   rx_bus (master)            : pkt/len writes, frame_done, fifo_full
//   rd_en, wr_en, data_in      : status read strobe, W1C write strobe and data
//   data_out                   : status byte captured on rd_en
// Build option: define RX_CHECKSUM_EN to add the trailing checksum byte and
// the CHECK state; without it a frame ends after its last payload byte and
// chk_err always reads 0.
module rx_lvds_deframer
  import rx_lvds_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter logic [7:0] MAX_LEN   = DEFAULT_MAX_LEN
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         from_lvds,
  rx_lvds_deframer_if.master rx_bus,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out
);

  rx_state_e  state_q;
  logic [7:0] len_q;
  logic [7:0] remain_q;
  logic [3:0] sticky_q;
  logic [3:0] frame_cnt_q;
  logic [7:0] data_out_q;
  logic       pkt_wr_en_q;
  logic [7:0] pkt_data_q;
  logic       len_wr_en_q;
  logic [7:0] len_data_q;
  logic       frame_done_q;
`ifdef RX_CHECKSUM_EN
  logic [7:0] sum_q;
`endif

  logic [7:0] sr_d;
  logic       byte_valid;
  logic       unused_data_in;

  // Upper status bits are read-only, so the matching write bits are ignored.
  assign unused_data_in = ^data_in[7:4];

  lvds_dibit_deser u_deser (
    .clk          (clk),
    .reset_n      (reset_n),
    .dibit_i      (from_lvds),
    .align_clr_i  (state_q == HUNT),
    .sr_d_o       (sr_d),
    .byte_valid_o (byte_valid)
  );

  assign rx_bus.pkt_wr_en  = pkt_wr_en_q;
  assign rx_bus.pkt_data   = pkt_data_q;
  assign rx_bus.len_wr_en  = len_wr_en_q;
  assign rx_bus.len_data   = len_data_q;
  assign rx_bus.frame_done = frame_done_q;
  assign data_out          = data_out_q;

  // Framing FSM with registered strobes and the status register.
  // The W1C clear is written before the FSM's set assignments so that, when
  // both hit the same bit in one clock, the later set assignment wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      len_q        <= 8'h00;
      remain_q     <= 8'h00;
      sticky_q     <= 4'h0;
      frame_cnt_q  <= 4'h0;
      data_out_q   <= 8'h00;
      pkt_wr_en_q  <= 1'b0;
      pkt_data_q   <= 8'h00;
      len_wr_en_q  <= 1'b0;
      len_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef RX_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      pkt_wr_en_q  <= 1'b0;
      len_wr_en_q  <= 1'b0;
      frame_done_q <= 1'b0;

      if (rd_en) begin
        data_out_q <= {frame_cnt_q, sticky_q};
      end
      if (wr_en) begin
        sticky_q <= sticky_q & ~data_in[3:0];
      end

      case (state_q)
        HUNT: begin
          if (sr_d == SYNC_WORD) begin
            state_q <= LEN;
          end
        end

        LEN: begin
          if (byte_valid) begin
            if (len_ok(sr_d, MAX_LEN)) begin
              len_q    <= sr_d;
              remain_q <= sr_d;
`ifdef RX_CHECKSUM_EN
              sum_q    <= 8'h00;
`endif
              state_q  <= PAYLOAD;
            end else begin
              sticky_q[STAT_LEN_ERR] <= 1'b1;
              state_q                <= HUNT;
            end
          end
        end

        PAYLOAD: begin
          if (byte_valid) begin
            if (rx_bus.fifo_full) begin
              // Drop the rest of the frame; no length is ever written for it.
              sticky_q[STAT_OVERFLOW] <= 1'b1;
              state_q                 <= HUNT;
            end else begin
              pkt_wr_en_q <= 1'b1;
              pkt_data_q  <= sr_d;
              remain_q    <= remain_q - 8'd1;
`ifdef RX_CHECKSUM_EN
              sum_q       <= sum_q + sr_d;
              if (remain_q == 8'd1) begin
                state_q <= CHECK;
              end
`else
              if (remain_q == 8'd1) begin
                len_wr_en_q             <= 1'b1;
                len_data_q              <= len_q;
                frame_done_q            <= 1'b1;
                sticky_q[STAT_FRAME_OK] <= 1'b1;
                frame_cnt_q             <= frame_cnt_q + 4'd1;
                state_q                 <= HUNT;
              end
`endif
            end
          end
        end

`ifdef RX_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            if (sr_d == sum_q) begin
              len_wr_en_q             <= 1'b1;
              len_data_q              <= len_q;
              frame_done_q            <= 1'b1;
              sticky_q[STAT_FRAME_OK] <= 1'b1;
              frame_cnt_q             <= frame_cnt_q + 4'd1;
            end else begin
              sticky_q[STAT_CHK_ERR] <= 1'b1;
            end
            state_q <= HUNT;
          end
        end
`endif

        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_lvds_deframer.sv
// tb_rx_lvds_deframer
// Directed bench for rx_lvds_deframer. Frames are driven dibit by dibit,
// a negedge monitor collects every pkt/len write, and each step compares the
// collected writes and the status register with hand-computed values.
// Follows the RX_CHECKSUM_EN build option of the design.
module tb_rx_lvds_deframer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk;
  logic       reset_n;
  logic [1:0] from_lvds;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks;
  int failures;
  int doneErr;

  logic [7:0] pktQ[$];
  logic [7:0] lenQ[$];
  logic [7:0] status;

  rx_lvds_deframer_if bus ();

  rx_lvds_deframer #(
    .SYNC_WORD (8'hA5),
    .MAX_LEN   (8'd64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .from_lvds (from_lvds),
    .rx_bus    (bus.master),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect every write seen on the bus, sampled mid-cycle, and note any
  // cycle where frame_done and len_wr_en disagree.
  always @(negedge clk) begin
    if (bus.pkt_wr_en === 1'b1) pktQ.push_back(bus.pkt_data);
    if (bus.len_wr_en === 1'b1) lenQ.push_back(bus.len_data);
    if (bus.frame_done !== bus.len_wr_en) doneErr++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One dibit per clock; inputs change 1 unit after the rising edge.
  task automatic applyStimulus(input logic [1:0] d);
    from_lvds = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b[7:6]);
    applyStimulus(b[5:4]);
    applyStimulus(b[3:2]);
    applyStimulus(b[1:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00);
  endtask

  task automatic readStatus(output logic [7:0] s);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    s = data_out;
  endtask

  task automatic writeStatus(input logic [7:0] d);
    wr_en   = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    data_in = 8'h00;
  endtask

  // Reference frame: sync, L=3, payload 11 22 33, checksum byte if enabled.
  task automatic sendStdFrame(input logic [7:0] chk);
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
`ifdef RX_CHECKSUM_EN
    sendByte(chk);
`else
    if (chk == 8'hFF) $display("[TB] note: checksum byte not sent");
`endif
  endtask

  task automatic clearLogs();
    pktQ.delete();
    lenQ.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    doneErr   = 0;
    reset_n   = 1'b0;
    from_lvds = 2'b00;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    data_in   = 8'h00;
    bus.fifo_full = 1'b0;

    // Reset values.
    #12;
    checkOutput("rst_pkt_wr_en", bus.pkt_wr_en, 1'b0);
    checkOutput("rst_len_wr_en", bus.len_wr_en, 1'b0);
    checkOutput("rst_frame_done", bus.frame_done, 1'b0);
    checkOutput("rst_data_out", data_out, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);
    readStatus(status);
    checkOutput("rst_status", status, 8'h00);

    // Aligned reference frame, with write timing checked one clock after
    // the 4th dibit of the first payload byte and of the final byte.
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(8'h11);
    checkOutput("a_first_wr_en", bus.pkt_wr_en, 1'b1);
    checkOutput("a_first_wr_data", bus.pkt_data, 8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
`ifdef RX_CHECKSUM_EN
    sendByte(8'h66);
`endif
    checkOutput("a_len_wr_en", bus.len_wr_en, 1'b1);
    checkOutput("a_frame_done", bus.frame_done, 1'b1);
    checkOutput("a_len_data", bus.len_data, 8'h03);
    idle(6);
    checkOutput("a_pkt_count", pktQ.size(), 3);
    checkOutput("a_pkt0", pktQ[0], 8'h11);
    checkOutput("a_pkt1", pktQ[1], 8'h22);
    checkOutput("a_pkt2", pktQ[2], 8'h33);
    checkOutput("a_len_count", lenQ.size(), 1);
    readStatus(status);
    checkOutput("a_status", status, 8'h11);

    // Same frame shifted by one dibit.
    writeStatus(8'h0F);
    clearLogs();
    idle(1);
    sendStdFrame(8'h66);
    idle(6);
    checkOutput("b_pkt_count", pktQ.size(), 3);
    checkOutput("b_pkt2", pktQ[2], 8'h33);
    checkOutput("b_len_count", lenQ.size(), 1);
    checkOutput("b_len0", lenQ[0], 8'h03);
    readStatus(status);
    checkOutput("b_status", status, 8'h21);

`ifdef RX_CHECKSUM_EN
    // Wrong checksum: payload still written, no length, chk_err set.
    writeStatus(8'h0F);
    clearLogs();
    sendStdFrame(8'h00);
    idle(6);
    checkOutput("c_pkt_count", pktQ.size(), 3);
    checkOutput("c_len_count", lenQ.size(), 0);
    readStatus(status);
    checkOutput("c_status", status, 8'h22);
`endif

    // Zero length.
    writeStatus(8'h0F);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h00);
    idle(8);
    checkOutput("l0_pkt_count", pktQ.size(), 0);
    checkOutput("l0_len_count", lenQ.size(), 0);
    readStatus(status);
    checkOutput("l0_status", status, 8'h24);

    // One past MAX_LEN, then a good frame is accepted again.
    writeStatus(8'h0F);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h41);
    idle(8);
    checkOutput("l41_pkt_count", pktQ.size(), 0);
    checkOutput("l41_len_count", lenQ.size(), 0);
    readStatus(status);
    checkOutput("l41_status", status, 8'h24);
    sendStdFrame(8'h66);
    idle(6);
    checkOutput("l41_next_pkt_count", pktQ.size(), 3);
    checkOutput("l41_next_len_count", lenQ.size(), 1);
    readStatus(status);
    checkOutput("l41_next_status", status, 8'h35);

    // Exactly MAX_LEN bytes, payload 00..3F, sum = 2016 mod 256 = E0.
    writeStatus(8'h0F);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h40);
    for (int i = 0; i < 64; i++) sendByte(8'(i));
`ifdef RX_CHECKSUM_EN
    sendByte(8'hE0);
`endif
    idle(6);
    checkOutput("max_pkt_count", pktQ.size(), 64);
    checkOutput("max_pkt_last", pktQ[63], 8'h3F);
    checkOutput("max_len0", lenQ[0], 8'h40);
    readStatus(status);
    checkOutput("max_status", status, 8'h41);

    // fifo_full at the second payload byte.
    writeStatus(8'h0F);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(8'h11);
    bus.fifo_full = 1'b1;
    sendByte(8'h22);
    bus.fifo_full = 1'b0;
    idle(8);
    checkOutput("ovf_pkt_count", pktQ.size(), 1);
    checkOutput("ovf_pkt0", pktQ[0], 8'h11);
    checkOutput("ovf_len_count", lenQ.size(), 0);
    readStatus(status);
    checkOutput("ovf_status", status, 8'h48);

    // Sync byte inside payload is data; reset mid-payload discards the frame.
    writeStatus(8'h0F);
    readStatus(status);
    checkOutput("sip_pre_status", status, 8'h40);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(SYNC);
    sendByte(8'h77);
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    checkOutput("sip_pkt_count", pktQ.size(), 2);
    checkOutput("sip_pkt0", pktQ[0], 8'hA5);
    checkOutput("sip_pkt1", pktQ[1], 8'h77);
    reset_n = 1'b0;
    #1;
    checkOutput("sip_rst_pkt_data", bus.pkt_data, 8'h00);
    checkOutput("sip_rst_len_data", bus.len_data, 8'h00);
    checkOutput("sip_rst_data_out", data_out, 8'h00);
    idle(2);
    reset_n = 1'b1;
    clearLogs();
    sendByte(8'h12);
    sendByte(8'h03);
    sendByte(8'h11);
    idle(8);
    checkOutput("sip_post_pkt_count", pktQ.size(), 0);
    checkOutput("sip_post_len_count", lenQ.size(), 0);
    readStatus(status);
    checkOutput("sip_post_status", status, 8'h00);
    sendStdFrame(8'h66);
    idle(6);
    checkOutput("sip_recover_len_count", lenQ.size(), 1);
    readStatus(status);
    checkOutput("sip_recover_status", status, 8'h11);

    // Build up sticky flags, then W1C bits 0 and 2.
    sendByte(SYNC);
    sendByte(8'h00);
    idle(8);
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(8'h11);
    bus.fifo_full = 1'b1;
    sendByte(8'h22);
    bus.fifo_full = 1'b0;
    idle(8);
`ifdef RX_CHECKSUM_EN
    sendStdFrame(8'h00);
    idle(6);
    readStatus(status);
    checkOutput("w1c_pre_status", status, 8'h1F);
    writeStatus(8'h05);
    readStatus(status);
    checkOutput("w1c_post_status", status, 8'h1A);
`else
    readStatus(status);
    checkOutput("w1c_pre_status", status, 8'h1D);
    writeStatus(8'h05);
    readStatus(status);
    checkOutput("w1c_post_status", status, 8'h18);
`endif

    // Clearing frame_ok in the very clock that sets it: the set wins.
    writeStatus(8'h0F);
    clearLogs();
    sendByte(SYNC);
    sendByte(8'h03);
    sendByte(8'h11);
    sendByte(8'h22);
`ifdef RX_CHECKSUM_EN
    sendByte(8'h33);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    wr_en   = 1'b1;
    data_in = 8'h01;
    applyStimulus(2'b10);
`else
    applyStimulus(2'b00);
    applyStimulus(2'b11);
    applyStimulus(2'b00);
    wr_en   = 1'b1;
    data_in = 8'h01;
    applyStimulus(2'b11);
`endif
    wr_en   = 1'b0;
    data_in = 8'h00;
    idle(6);
    checkOutput("race_len_count", lenQ.size(), 1);
    readStatus(status);
    checkOutput("race_status", status, 8'h21);

    checkOutput("done_with_len", doneErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
